// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose destination feeds the ID instruction stalls the front end for one cycle.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic              id_ALU_src,
  input  logic              id_WB_data_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [1:0]        id_ALU_op,
  input  logic [1:0]        id_ctrl_transfer,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_ALU_src,
  output logic              ex_WB_data_src,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [1:0]        ex_ALU_op,
  output logic [1:0]        ex_ctrl_transfer,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              ex_valid,
  output logic              stall,
  output logic [15:0]       stall_count
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                     vld_p1;
  logic                     alu_src_p1;
  logic                     wb_src_p1;
  logic                     reg_write_p1;
  logic                     mem_read_p1;
  logic                     mem_write_p1;
  logic [1:0]               alu_op_p1;
  logic [1:0]               ctrl_xfer_p1;
  logic [DATA_W-1:0]        pc_p1;
  logic signed [DATA_W-1:0] rd1_p1;
  logic signed [DATA_W-1:0] rd2_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]               rs1_p1;
  logic [4:0]               rs2_p1;
  logic [4:0]               rd_p1;
  logic [2:0]               funct3_p1;
  logic [6:0]               funct7_p1;
  logic [15:0]              stall_cnt_q;

  logic use_rs1;
  logic use_rs2;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;
  logic bubble;

  // ID stage (p0): hazard detection against the instruction held in EX
  always_comb begin
    use_rs1  = (id_opcode != OPC_JAL);
    use_rs2  = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
               (id_opcode == OPC_BRANCH);
    rs1_hit  = use_rs1 && (rd_p1 == id_rs1);
    rs2_hit  = use_rs2 && (rd_p1 == id_rs2);
    load_use = id_valid && vld_p1 && mem_read_p1 && (rd_p1 != 5'd0) &&
               (rs1_hit || rs2_hit);
    stall    = load_use && !flush;
    bubble   = flush || stall || !id_valid;
  end

  // EX stage (p1): control fields; a bubble clears them so the hazard cannot re-fire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      alu_src_p1   <= 1'b0;
      wb_src_p1    <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      alu_op_p1    <= 2'd0;
      ctrl_xfer_p1 <= 2'd0;
    end else if (bubble) begin
      vld_p1       <= 1'b0;
      alu_src_p1   <= 1'b0;
      wb_src_p1    <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
      alu_op_p1    <= 2'd0;
      ctrl_xfer_p1 <= 2'd0;
    end else begin
      vld_p1       <= 1'b1;
      alu_src_p1   <= id_ALU_src;
      wb_src_p1    <= id_WB_data_src;
      reg_write_p1 <= id_reg_write;
      mem_read_p1  <= id_mem_read;
      mem_write_p1 <= id_mem_write;
      alu_op_p1    <= id_ALU_op;
      ctrl_xfer_p1 <= id_ctrl_transfer;
    end
  end

  // Data fields are zeroed on reset and bubble too, so a dead slot is all-zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      rs1_p1    <= 5'd0;
      rs2_p1    <= 5'd0;
      rd_p1     <= 5'd0;
      funct3_p1 <= 3'd0;
      funct7_p1 <= 7'd0;
    end else if (bubble) begin
      pc_p1     <= '0;
      rd1_p1    <= '0;
      rd2_p1    <= '0;
      imm_p1    <= '0;
      rs1_p1    <= 5'd0;
      rs2_p1    <= 5'd0;
      rd_p1     <= 5'd0;
      funct3_p1 <= 3'd0;
      funct7_p1 <= 7'd0;
    end else begin
      pc_p1     <= id_pc;
      rd1_p1    <= id_rd1;
      rd2_p1    <= id_rd2;
      imm_p1    <= id_imm;
      rs1_p1    <= id_rs1;
      rs2_p1    <= id_rs2;
      rd_p1     <= id_rd;
      funct3_p1 <= id_funct3;
      funct7_p1 <= id_funct7;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if (stall) begin
      stall_cnt_q <= sat_inc16(stall_cnt_q);
    end
  end

  assign ex_valid         = vld_p1;
  assign ex_ALU_src       = alu_src_p1;
  assign ex_WB_data_src   = wb_src_p1;
  assign ex_reg_write     = reg_write_p1;
  assign ex_mem_read      = mem_read_p1;
  assign ex_mem_write     = mem_write_p1;
  assign ex_ALU_op        = alu_op_p1;
  assign ex_ctrl_transfer = ctrl_xfer_p1;
  assign ex_pc            = pc_p1;
  assign ex_rd1           = rd1_p1;
  assign ex_rd2           = rd2_p1;
  assign ex_imm           = imm_p1;
  assign ex_rs1           = rs1_p1;
  assign ex_rs2           = rs2_p1;
  assign ex_rd            = rd_p1;
  assign ex_funct3        = funct3_p1;
  assign ex_funct7        = funct7_p1;
  assign stall_count      = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a transaction-level model.
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  typedef struct packed {
    logic        alu_src;
    logic        wb_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  alu_op;
    logic [1:0]  ctrl;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } fields_t;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] JALR   = 7'b1100111;

  logic clk = 1'b0;
  logic reset;
  logic id_valid;
  logic flush;
  logic [6:0] opc;
  fields_t in;
  fields_t ex_obs;

  logic ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [1:0] ex_ALU_op, ex_ctrl_transfer;
  logic [DATA_W-1:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [2:0] ex_funct3;
  logic [6:0] ex_funct7;
  logic ex_valid, stall;
  logic [15:0] stall_count;

  // Reference model state: what EX should hold and how many stalls were seen
  logic    m_vld;
  fields_t m_ex;
  int      m_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(opc),
    .id_ALU_src(in.alu_src), .id_WB_data_src(in.wb_src), .id_reg_write(in.reg_write),
    .id_mem_read(in.mem_read), .id_mem_write(in.mem_write), .id_ALU_op(in.alu_op),
    .id_ctrl_transfer(in.ctrl), .id_pc(in.pc), .id_rd1(in.rd1), .id_rd2(in.rd2),
    .id_imm(in.imm), .id_rs1(in.rs1), .id_rs2(in.rs2), .id_rd(in.rd),
    .id_funct3(in.f3), .id_funct7(in.f7), .flush(flush),
    .ex_ALU_src(ex_ALU_src), .ex_WB_data_src(ex_WB_data_src), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_ALU_op(ex_ALU_op),
    .ex_ctrl_transfer(ex_ctrl_transfer), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_valid(ex_valid),
    .stall(stall), .stall_count(stall_count)
  );

  assign ex_obs = {ex_ALU_src, ex_WB_data_src, ex_reg_write, ex_mem_read, ex_mem_write,
                   ex_ALU_op, ex_ctrl_transfer, ex_pc, ex_rd1, ex_rd2, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // The ID instruction depends on the EX load if it reads the load's non-zero destination
  function automatic bit model_hazard();
    bit reads_rs1, reads_rs2;
    if (!(id_valid && m_vld && m_ex.mem_read)) return 1'b0;
    if (m_ex.rd == 5'd0) return 1'b0;
    reads_rs1 = (opc != JAL);
    reads_rs2 = (opc == OP) || (opc == STORE) || (opc == BRANCH);
    return (reads_rs1 && in.rs1 == m_ex.rd) || (reads_rs2 && in.rs2 == m_ex.rd);
  endfunction

  function automatic bit model_stall();
    return model_hazard() && !flush;
  endfunction

  task automatic model_reset();
    m_vld = 1'b0;
    m_ex  = '0;
    m_cnt = 0;
  endtask

  task automatic pre_check();
    #1;
    chk("stall", 256'(stall), 256'(model_stall()));
  endtask

  task automatic clk_edge();
    bit st;
    st = model_stall();
    if (flush || st || !id_valid) begin
      m_vld = 1'b0;
      m_ex  = '0;
    end else begin
      m_vld = 1'b1;
      m_ex  = in;
    end
    if (st && m_cnt < 65535) m_cnt = m_cnt + 1;
    @(posedge clk);
    #1;
    chk("ex_valid", 256'(ex_valid), 256'(m_vld));
    chk("ex_fields", 256'(ex_obs), 256'(m_ex));
    chk("stall_count", 256'(stall_count), 256'(m_cnt));
    @(negedge clk);
  endtask

  task automatic run_cycle();
    pre_check();
    clk_edge();
  endtask

  task automatic set_id(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic mr, input logic rw);
    in = '0;
    opc = op;
    in.rs1 = rs1;
    in.rs2 = rs2;
    in.rd = rd;
    in.mem_read = mr;
    in.reg_write = rw;
    id_valid = 1'b1;
    flush = 1'b0;
  endtask

  task automatic randomize_id();
    logic [6:0] tab [7];
    tab = '{LOAD, OP, STORE, BRANCH, JAL, OP_IMM, JALR};
    opc = tab[$urandom_range(0, 6)];
    in.alu_src   = 1'($urandom);
    in.wb_src    = 1'($urandom);
    in.reg_write = 1'($urandom);
    in.mem_read  = 1'($urandom);
    in.mem_write = 1'($urandom);
    in.alu_op    = 2'($urandom);
    in.ctrl      = 2'($urandom);
    in.pc        = $urandom;
    in.rd1       = $urandom;
    in.rd2       = $urandom;
    in.imm       = $urandom;
    in.rs1       = 5'($urandom_range(0, 3));
    in.rs2       = 5'($urandom_range(0, 3));
    in.rd        = 5'($urandom_range(0, 3));
    in.f3        = 3'($urandom);
    in.f7        = 7'($urandom);
    id_valid     = ($urandom_range(0, 9) != 0);
    flush        = ($urandom_range(0, 9) == 0);
  endtask

  task automatic no_hazard_case(input string tag, input logic [4:0] ld_rd, input logic [6:0] op,
                                input logic [4:0] rs1, input logic [4:0] rs2);
    set_id(LOAD, 5'd1, 5'd0, ld_rd, 1'b1, 1'b1);
    run_cycle();
    set_id(op, rs1, rs2, 5'd9, 1'b0, 1'b1);
    #1;
    chk(tag, 256'(stall), 256'(0));
    chk("stall", 256'(stall), 256'(model_stall()));
    clk_edge();
  endtask

  initial begin
    reset = 1'b1;
    in = '0;
    opc = OP;
    id_valid = 1'b1;
    flush = 1'b0;
    model_reset();

    // Reset state, before and at a clock edge
    #3;
    chk("rst_ex_valid", 256'(ex_valid), 256'(0));
    chk("rst_ex_fields", 256'(ex_obs), 256'(0));
    chk("rst_stall_count", 256'(stall_count), 256'(0));
    in.rd1 = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("rst_hold_ex_valid", 256'(ex_valid), 256'(0));
    chk("rst_hold_fields", 256'(ex_obs), 256'(0));
    @(negedge clk);
    reset = 1'b0;

    // Pass-through ADD
    set_id(OP, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
    in.rd1 = 32'd5;
    in.rd2 = 32'd7;
    in.alu_op = 2'b01;
    run_cycle();
    chk("pt_rd1", 256'(ex_rd1), 256'(5));
    chk("pt_rd2", 256'(ex_rd2), 256'(7));
    chk("pt_rd", 256'(ex_rd), 256'(3));
    chk("pt_reg_write", 256'(ex_reg_write), 256'(1));
    chk("pt_alu_op", 256'(ex_ALU_op), 256'(2'b01));
    chk("pt_valid", 256'(ex_valid), 256'(1));

    // Load-use: LW x5 then ADD x6,x5,x1
    set_id(LOAD, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    run_cycle();
    set_id(OP, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
    #1;
    chk("lu_stall", 256'(stall), 256'(1));
    clk_edge();
    chk("lu_bubble_valid", 256'(ex_valid), 256'(0));
    chk("lu_bubble_rw", 256'(ex_reg_write), 256'(0));
    #1;
    chk("lu_stall_released", 256'(stall), 256'(0));
    clk_edge();
    chk("lu_add_valid", 256'(ex_valid), 256'(1));
    chk("lu_add_rd", 256'(ex_rd), 256'(6));
    chk("lu_count", 256'(stall_count), 256'(1));

    // Both sources hit the same load: one stall, one bubble
    set_id(LOAD, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);
    run_cycle();
    set_id(OP, 5'd7, 5'd7, 5'd8, 1'b0, 1'b1);
    run_cycle();
    run_cycle();
    chk("dual_count", 256'(stall_count), 256'(2));

    // No false hazards
    no_hazard_case("nh_x0", 5'd0, OP, 5'd0, 5'd0);
    no_hazard_case("nh_jal", 5'd5, JAL, 5'd5, 5'd0);
    no_hazard_case("nh_opimm", 5'd5, OP_IMM, 5'd1, 5'd5);

    // Flush wins over a live hazard
    set_id(LOAD, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    run_cycle();
    set_id(OP, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_stall", 256'(stall), 256'(0));
    clk_edge();
    chk("fl_bubble", 256'(ex_valid), 256'(0));
    chk("fl_count", 256'(stall_count), 256'(2));
    flush = 1'b0;

    // Asynchronous reset mid-stall, then normal capture on the next edge
    set_id(LOAD, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
    run_cycle();
    set_id(OP, 5'd5, 5'd1, 5'd6, 1'b0, 1'b1);
    pre_check();
    #1;
    reset = 1'b1;
    #1;
    chk("ar_ex_valid", 256'(ex_valid), 256'(0));
    chk("ar_fields", 256'(ex_obs), 256'(0));
    chk("ar_stall", 256'(stall), 256'(0));
    chk("ar_count", 256'(stall_count), 256'(0));
    model_reset();
    reset = 1'b0;
    clk_edge();
    chk("ar_capture_rd", 256'(ex_rd), 256'(6));

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      randomize_id();
      run_cycle();
    end

    // Saturation from a preloaded count
    set_id(OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    run_cycle();
    force dut.stall_cnt_q = 16'hFFFC;
    #1;
    release dut.stall_cnt_q;
    m_cnt = 16'hFFFC;
    #1;
    chk("sat_preload", 256'(stall_count), 256'(16'hFFFC));
    for (int k = 0; k < 6; k++) begin
      set_id(LOAD, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1);
      run_cycle();
      set_id(OP, 5'd5, 5'd2, 5'd6, 1'b0, 1'b1);
      run_cycle();
    end
    chk("sat_hold", 256'(stall_count), 256'(16'hFFFF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
